cpu_alu: RTL and testbench

Sequential 8-bit ALU and flag register of the Intel8008 core, sitting directly downstream of the alpha/beta temporary registers. The accumulator operand arrives on DAT_A_I and the temp-register operand on DAT_B_I. The block captures both on a start strobe, computes over a fixed 3-state sequence, then registers the result and the S/Z/P/C flags. The control sequencer reads the result and flags after DONE_O.

---
 rtl/cpu_alu.sv | 104 ++++++++++
 tb/tb_cpu_alu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// Sequential 8-bit ALU with S/Z/P/C flag register for the 8008 core: capture on strobe, compute, register result.
// Optional external flag load port group enabled by defining CPU_ALU_FLGLOAD_EN.
module cpu_alu (
  input  logic       CLK_I,
  input  logic       nRST_I,
  input  logic       STB_I,
  input  logic [3:0] OP_I,
  input  logic [7:0] DAT_A_I,
  input  logic [7:0] DAT_B_I,
  output logic [7:0] DAT_O,
  output logic [3:0] FLG_O,
  output logic       BUSY_O,
  output logic       DONE_O
`ifdef CPU_ALU_FLGLOAD_EN
  ,
  input  logic       FLG_WR_I,
  input  logic [3:0] FLG_I
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

  state_t   state, state_n;
  alu_req_t req;
  logic     accept;

  logic [8:0] r9;
  logic [7:0] res;
  logic       c_new;
  logic       upd_szp;
  logic       res_wr;
  logic [3:0] flg_n;
  logic       cin;

  assign accept = (state == IDLE) && STB_I;
  assign BUSY_O = (state != IDLE);
  assign DONE_O = (state == DONE);
  assign cin    = FLG_O[0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (STB_I) state_n = EXEC;
      EXEC:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Subtraction borrow falls out of bit 8 of the 9-bit difference.
  always_comb begin
    r9      = 9'd0;
    c_new   = cin;
    upd_szp = 1'b1;
    res_wr  = 1'b1;
    case (req.op)
      4'h0: begin r9 = {1'b0, req.a} + {1'b0, req.b};              c_new = r9[8]; end
      4'h1: begin r9 = {1'b0, req.a} + {1'b0, req.b} + {8'd0, cin}; c_new = r9[8]; end
      4'h2: begin r9 = {1'b0, req.a} - {1'b0, req.b};              c_new = r9[8]; end
      4'h3: begin r9 = {1'b0, req.a} - {1'b0, req.b} - {8'd0, cin}; c_new = r9[8]; end
      4'h4: begin r9 = {1'b0, req.a & req.b}; c_new = 1'b0; end
      4'h5: begin r9 = {1'b0, req.a ^ req.b}; c_new = 1'b0; end
      4'h6: begin r9 = {1'b0, req.a | req.b}; c_new = 1'b0; end
      4'h7: begin r9 = {1'b0, req.a} - {1'b0, req.b}; c_new = r9[8]; res_wr = 1'b0; end
      4'h8: begin r9 = {1'b0, req.a[6:0], req.a[7]}; c_new = req.a[7]; upd_szp = 1'b0; end
      4'h9: begin r9 = {1'b0, req.a[0], req.a[7:1]}; c_new = req.a[0]; upd_szp = 1'b0; end
      4'hA: begin r9 = {1'b0, req.a[6:0], cin};      c_new = req.a[7]; upd_szp = 1'b0; end
      4'hB: begin r9 = {1'b0, cin, req.a[7:1]};      c_new = req.a[0]; upd_szp = 1'b0; end
      4'hC: begin r9 = {1'b0, req.b} + 9'd1; end
      4'hD: begin r9 = {1'b0, req.b} - 9'd1; end
      default: begin r9 = {1'b0, req.b}; upd_szp = 1'b0; end
    endcase
    res   = r9[7:0];
    flg_n = upd_szp ? {res[7], (res == 8'd0), ~^res, c_new}
                    : {FLG_O[3:1], c_new};
  end

  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      state <= IDLE;
      req   <= '0;
      DAT_O <= 8'h00;
      FLG_O <= 4'h0;
    end else begin
      state <= state_n;
      if (accept) req <= '{op: OP_I, a: DAT_A_I, b: DAT_B_I};
      if (state == EXEC) begin
        if (res_wr) DAT_O <= res;
        FLG_O <= flg_n;
      end
`ifdef CPU_ALU_FLGLOAD_EN
      // Strobe has priority: a flag load coinciding with an accept is dropped.
      else if (state == IDLE && !STB_I && FLG_WR_I) FLG_O <= FLG_I;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_alu.sv
// Directed + random checks of cpu_alu against an arithmetic reference model.
module tb_cpu_alu;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       stb = 1'b0;
  logic [3:0] op = 4'h0;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic [7:0] dat;
  logic [3:0] flg;
  logic       busy, done;
`ifdef CPU_ALU_FLGLOAD_EN
  logic       flg_wr = 1'b0;
  logic [3:0] flg_in = 4'h0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m_dat;
  logic [3:0] m_flg;

  cpu_alu dut (
    .CLK_I(clk), .nRST_I(nrst), .STB_I(stb), .OP_I(op),
    .DAT_A_I(da), .DAT_B_I(db), .DAT_O(dat), .FLG_O(flg),
    .BUSY_O(busy), .DONE_O(done)
`ifdef CPU_ALU_FLGLOAD_EN
    , .FLG_WR_I(flg_wr), .FLG_I(flg_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: computes the new result/flags from the opcode rules with integer math.
  task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, ci, r;
    bit c, keep_szp;
    logic [7:0] res;
    ia = a; ib = b; ci = m_flg[0]; keep_szp = 0; c = m_flg[0];
    case (o)
      4'h0: begin r = ia + ib;      c = (r > 255); end
      4'h1: begin r = ia + ib + ci; c = (r > 255); end
      4'h2, 4'h7: begin r = ia - ib; c = (ia < ib); end
      4'h3: begin r = ia - ib - ci; c = (ia < ib + ci); end
      4'h4: begin r = a & b; c = 0; end
      4'h5: begin r = a ^ b; c = 0; end
      4'h6: begin r = a | b; c = 0; end
      4'h8: begin r = (ia * 2) % 256 + ia / 128; c = (ia >= 128); keep_szp = 1; end
      4'h9: begin r = ia / 2 + (ia % 2) * 128;  c = (ia % 2 == 1); keep_szp = 1; end
      4'hA: begin r = (ia * 2) % 256 + ci;      c = (ia >= 128); keep_szp = 1; end
      4'hB: begin r = ia / 2 + ci * 128;        c = (ia % 2 == 1); keep_szp = 1; end
      4'hC: r = ib + 1;
      4'hD: r = ib - 1;
      default: begin r = ib; keep_szp = 1; end
    endcase
    res = 8'(r & 255);
    if (!keep_szp) m_flg[3:1] = {(res >= 8'd128), (res == 8'd0), ($countones(res) % 2 == 0)};
    m_flg[0] = c;
    if (o != 4'h7) m_dat = res;
  endtask

  // One operation; hold_stb keeps the strobe high (with OP=ANA) through EXEC and DONE.
  task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input bit hold_stb);
    model(o, a, b);
    @(negedge clk);
    stb = 1; op = o; da = a; db = b;
    @(posedge clk); #1;
    chk("busy_exec", 8'(busy), 8'd1);
    chk("done_exec", 8'(done), 8'd0);
    stb = hold_stb; op = 4'h4; da = 8'($urandom); db = 8'($urandom);
    @(posedge clk); #1;
    chk($sformatf("dat op%h", o), dat, m_dat);
    chk($sformatf("flg op%h", o), 8'(flg), 8'(m_flg));
    chk("done_pulse", 8'(done), 8'd1);
    @(posedge clk); #1;
    stb = 0;
    chk("done_end", 8'(done), 8'd0);
    chk("busy_end", 8'(busy), 8'd0);
  endtask

  initial begin
    m_dat = 8'h00; m_flg = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dat", dat, 8'h00);
    chk("rst_flg", 8'(flg), 8'h0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    nrst = 1;

    do_op(4'h0, 8'h7F, 8'h81, 0); chk("add_lit", {dat, flg} >> 4, {8'h00, 4'h7} >> 4); chk("add_flg", 8'(flg), 8'h7);
    do_op(4'h3, 8'h10, 8'h10, 0); chk("sbb_dat", dat, 8'hFF); chk("sbb_flg", 8'(flg), 8'b1011);
    do_op(4'h1, 8'h01, 8'h01, 0); chk("adc_dat", dat, 8'h03); chk("adc_flg", 8'(flg), 8'b0010);
    do_op(4'hE, 8'h00, 8'h3C, 0);
    do_op(4'h7, 8'h05, 8'h06, 0); chk("cmp_dat", dat, 8'h3C); chk("cmp_flg", 8'(flg), 8'b1011);
    do_op(4'hF, 8'h00, 8'hAA, 0); chk("pass_dat", dat, 8'hAA); chk("pass_flg", 8'(flg), 8'b1011);
    do_op(4'h6, 8'h01, 8'h00, 0); chk("ora_flg", 8'(flg), 8'h0);
    do_op(4'hA, 8'h80, 8'h00, 0); chk("ral_dat", dat, 8'h00); chk("ral_flg", 8'(flg), 8'b0001);
    do_op(4'hC, 8'h00, 8'hFF, 0); chk("inr_dat", dat, 8'h00); chk("inr_flg", 8'(flg), 8'b0111);
    do_op(4'hD, 8'h00, 8'h00, 0); chk("dcr_dat", dat, 8'hFF); chk("dcr_flg", 8'(flg), 8'b1011);

    // Strobe held through EXEC and DONE must not start a second op.
    do_op(4'h5, 8'hF0, 8'h3C, 1); chk("ign_dat", dat, 8'hCC);
    @(posedge clk); #1;
    chk("ign_busy", 8'(busy), 8'd0);
    chk("ign_dat2", dat, 8'hCC);

    // Reset during EXEC aborts without a result write or DONE pulse.
    @(negedge clk); stb = 1; op = 4'h0; da = 8'h12; db = 8'h34;
    @(posedge clk); #1; stb = 0;
    chk("mid_busy", 8'(busy), 8'd1);
    @(negedge clk); nrst = 0;
    @(posedge clk); #1;
    chk("mid_dat", dat, 8'h00);
    chk("mid_flg", 8'(flg), 8'h0);
    chk("mid_busy0", 8'(busy), 8'd0);
    chk("mid_done0", 8'(done), 8'd0);
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;
    chk("mid_done1", 8'(done), 8'd0);
    m_dat = 8'h00; m_flg = 4'h0;

    for (int i = 0; i < 60; i++)
      do_op(4'($urandom), 8'($urandom), 8'($urandom), 0);

`ifdef CPU_ALU_FLGLOAD_EN
    @(negedge clk); flg_wr = 1; flg_in = 4'hA;
    @(posedge clk); #1; flg_wr = 0;
    chk("flgload", 8'(flg), 8'hA);
    m_flg = 4'hA;
    do_op(4'h1, 8'h01, 8'h01, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
